// File: rtl/rx_5b4b_decode_9600_if.sv
// Output bus of the 5B/4B line decoder.
// Signals:
//   DATA        - last successfully decoded byte
//   DATA_VALID  - one-cycle strobe when DATA updates
//   ERR_FRAME   - sticky, a stop bit was sampled low
//   ERR_CODE    - sticky, a received symbol was outside the code table
//   ERR_OVERRUN - sticky, a decoded byte was dropped on the transmit side
//   LED         - copy of DATA for the board LEDs
// The decoder drives the bus through the master modport; observers use slave.
interface rx_5b4b_decode_9600_if;
  logic [7:0] DATA;
  logic       DATA_VALID;
  logic       ERR_FRAME;
  logic       ERR_CODE;
  logic       ERR_OVERRUN;
  logic [7:0] LED;

  modport master (output DATA, DATA_VALID, ERR_FRAME, ERR_CODE, ERR_OVERRUN, LED);
  modport slave  (input  DATA, DATA_VALID, ERR_FRAME, ERR_CODE, ERR_OVERRUN, LED);
endinterface

// File: rtl/rx_5b4b_decode_9600.sv
// 5B/4B frame receiver with an 8N1 re-transmitter.
// Receives a 12-bit line frame (start 0, symbol s0, symbol s1, stop 1),
// decodes the two 5-bit symbols into one byte, publishes it on the bus and
// re-sends it as standard 8N1 on the RS-232 TXD pin.
// Ports:
//   CLK_50M       - system clock, all logic on the rising edge
//   RST           - synchronous active-high reset
//   LINE_RXD      - encoded serial input (asynchronous, idle high)
//   RS232_DTE_TXD - decoded byte as 8N1, LSB first, idle high
//   bus           - decoded data, strobe, LEDs and sticky error flags
module rx_5b4b_decode_9600 #(
  parameter int CLKS_PER_BIT_IN  = 4340,
  parameter int CLKS_PER_BIT_OUT = 5208
) (
  input  logic                         CLK_50M,
  input  logic                         RST,
  input  logic                         LINE_RXD,
  output logic                         RS232_DTE_TXD,
  rx_5b4b_decode_9600_if.master        bus
);

  localparam int IN_W  = $clog2(CLKS_PER_BIT_IN);
  localparam int OUT_W = $clog2(CLKS_PER_BIT_OUT);
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(CLKS_PER_BIT_IN - 1);
  localparam logic [IN_W-1:0]  IN_HALF  = IN_W'(CLKS_PER_BIT_IN / 2 - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(CLKS_PER_BIT_OUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Returns {valid, nibble}; codes outside the table come back invalid.
  function automatic logic [4:0] decode_sym(input logic [4:0] s);
    case (s)
      5'b11110: return 5'h10;
      5'b01001: return 5'h11;
      5'b10100: return 5'h12;
      5'b10101: return 5'h13;
      5'b01010: return 5'h14;
      5'b01011: return 5'h15;
      5'b01110: return 5'h16;
      5'b01111: return 5'h17;
      5'b10010: return 5'h18;
      5'b10011: return 5'h19;
      5'b10110: return 5'h1A;
      5'b10111: return 5'h1B;
      5'b11010: return 5'h1C;
      5'b11011: return 5'h1D;
      5'b11100: return 5'h1E;
      5'b11101: return 5'h1F;
      default:  return 5'h00;
    endcase
  endfunction

  logic rx_meta, rx_sync, rx_prev, rx_fall;
  rx_state_t rx_state, rx_next;
  logic [IN_W-1:0] rx_cnt;
  logic [3:0] rx_bits;
  logic [9:0] rx_shift;
  logic rx_tick, stop_tick, frame_ok, byte_ok;
  logic [4:0] dec0, dec1;
  logic [7:0] rx_byte;

  logic [7:0] data_q;
  logic data_valid_q, err_frame_q, err_code_q, err_overrun_q;

  logic tx_busy, tx_done, hold_full, txd_q;
  logic [9:0] tx_shift;
  logic [3:0] tx_bits;
  logic [OUT_W-1:0] tx_cnt;
  logic [7:0] hold_data;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= LINE_RXD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // The start bit is checked half a bit in; every later sample is a full bit
  // after the previous one, so all samples land near bit centres.
  always_comb begin
    rx_tick = (rx_state == RX_START) ? (rx_cnt == IN_HALF) : (rx_cnt == IN_LAST);
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bits == 4'd9) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // Bit timer and shift register; bits enter at the top so that after ten
  // samples s0 sits in [4:0] and s1 in [9:5], each with its bit 0 lowest.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_IDLE) begin
        rx_bits <= '0;
      end else if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[9:1]};
        rx_bits  <= rx_bits + 1'b1;
      end
    end
  end

  // Decode both symbols at the stop-bit sample.
  always_comb begin
    stop_tick = (rx_state == RX_STOP) && rx_tick;
    frame_ok  = stop_tick && rx_sync;
    dec0      = decode_sym(rx_shift[4:0]);
    dec1      = decode_sym(rx_shift[9:5]);
    byte_ok   = frame_ok && dec0[4] && dec1[4];
    rx_byte   = {dec1[3:0], dec0[3:0]};
  end

  // Published byte, strobe and receive-side sticky flags.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      err_frame_q  <= 1'b0;
      err_code_q   <= 1'b0;
    end else begin
      data_valid_q <= byte_ok;
      if (byte_ok) data_q <= rx_byte;
      if (stop_tick && !rx_sync) err_frame_q <= 1'b1;
      if (frame_ok && !(dec0[4] && dec1[4])) err_code_q <= 1'b1;
    end
  end

  assign tx_done = tx_busy && (tx_bits == 4'd9) && (tx_cnt == OUT_LAST);

  // Transmitter with a one-byte holding register. When the transmitter is
  // free (idle, or finishing its stop bit this cycle) the holding register
  // drains first and a byte arriving in the same cycle takes its place, so
  // the finish/arrival coincidence never loses data. TXD is registered, so
  // the start bit appears the cycle after the byte is loaded.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      tx_busy       <= 1'b0;
      tx_shift      <= '1;
      tx_bits       <= '0;
      tx_cnt        <= '0;
      hold_full     <= 1'b0;
      hold_data     <= '0;
      txd_q         <= 1'b1;
      err_overrun_q <= 1'b0;
    end else begin
      txd_q <= tx_busy ? tx_shift[0] : 1'b1;
      if (tx_busy) begin
        if (tx_cnt == OUT_LAST) begin
          tx_cnt   <= '0;
          tx_bits  <= tx_bits + 1'b1;
          tx_shift <= {1'b1, tx_shift[9:1]};
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
      if (!tx_busy || tx_done) begin
        if (hold_full) begin
          tx_busy  <= 1'b1;
          tx_shift <= {1'b1, hold_data, 1'b0};
          tx_cnt   <= '0;
          tx_bits  <= '0;
          if (byte_ok) hold_data <= rx_byte;
          else         hold_full <= 1'b0;
        end else if (byte_ok) begin
          tx_busy  <= 1'b1;
          tx_shift <= {1'b1, rx_byte, 1'b0};
          tx_cnt   <= '0;
          tx_bits  <= '0;
        end else if (tx_done) begin
          tx_busy <= 1'b0;
        end
      end else if (byte_ok) begin
        if (hold_full) begin
          err_overrun_q <= 1'b1;
        end else begin
          hold_data <= rx_byte;
          hold_full <= 1'b1;
        end
      end
    end
  end

  assign RS232_DTE_TXD   = txd_q;
  assign bus.DATA        = data_q;
  assign bus.LED         = data_q;
  assign bus.DATA_VALID  = data_valid_q;
  assign bus.ERR_FRAME   = err_frame_q;
  assign bus.ERR_CODE    = err_code_q;
  assign bus.ERR_OVERRUN = err_overrun_q;

endmodule

// File: tb/tb_rx_5b4b_decode_9600.sv
// Testbench for rx_5b4b_decode_9600.
// Two decoder instances with shortened bit times: dut_a keeps the
// 12 x in-bit == 10 x out-bit balance of the real rates, dut_b has a slow
// transmitter so the holding register overflows. Expected bytes are pushed
// to scoreboard queues when frames are sent and popped by the bus and TXD
// monitors.
module tb_rx_5b4b_decode_9600;
  localparam int BIT_IN    = 10;
  localparam int BIT_OUT_A = 12;
  localparam int BIT_OUT_B = 25;

  logic clk = 1'b0;
  logic rst_a, rst_b, line_a, line_b, txd_a, txd_b;
  logic tx_mon, mon_sel, mon_en;
  int   tx_per;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [4:0] code_tab [16];
  logic [7:0] rx_got, rx_led, rx_exp, tx_got;
  logic tx_start, tx_stop;
  int   lows;

  always #5 clk = ~clk;

  rx_5b4b_decode_9600_if bus_a ();
  rx_5b4b_decode_9600_if bus_b ();

  rx_5b4b_decode_9600 #(.CLKS_PER_BIT_IN(BIT_IN), .CLKS_PER_BIT_OUT(BIT_OUT_A)) dut_a (
    .CLK_50M(clk), .RST(rst_a), .LINE_RXD(line_a), .RS232_DTE_TXD(txd_a), .bus(bus_a));

  rx_5b4b_decode_9600 #(.CLKS_PER_BIT_IN(BIT_IN), .CLKS_PER_BIT_OUT(BIT_OUT_B)) dut_b (
    .CLK_50M(clk), .RST(rst_b), .LINE_RXD(line_b), .RS232_DTE_TXD(txd_b), .bus(bus_b));

  assign tx_mon = mon_sel ? txd_b : txd_a;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Frame bit 0 is the start bit and goes out first.
  task automatic send_symbols(input bit to_b, input logic [4:0] s0,
                              input logic [4:0] s1, input logic stop_bit);
    logic [11:0] frame;
    frame = {stop_bit, s1, s0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      if (to_b) line_b = frame[i];
      else      line_a = frame[i];
      repeat (BIT_IN) @(negedge clk);
    end
  endtask

  task automatic send_byte(input bit to_b, input logic [7:0] b, input bit expect_tx);
    rx_q.push_back(b);
    if (expect_tx) tx_q.push_back(b);
    send_symbols(to_b, code_tab[b[3:0]], code_tab[b[7:4]], 1'b1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, rx_q.size() + tx_q.size(), 0);
  endtask

  task automatic count_tx_low(input int cycles, output int n_low);
    n_low = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_mon !== 1'b1) n_low++;
    end
  endtask

  // Bus monitor: every DATA_VALID strobe must match the next expected byte.
  always @(negedge clk) begin
    if (bus_a.DATA_VALID === 1'b1 || bus_b.DATA_VALID === 1'b1) begin
      rx_got = (bus_a.DATA_VALID === 1'b1) ? bus_a.DATA : bus_b.DATA;
      rx_led = (bus_a.DATA_VALID === 1'b1) ? bus_a.LED  : bus_b.LED;
      if (rx_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL spurious DATA_VALID: observed data 0x%0h, none expected", rx_got);
      end else begin
        rx_exp = rx_q.pop_front();
        check_output("DATA on strobe", rx_got, rx_exp);
        check_output("LED on strobe", rx_led, rx_exp);
      end
    end
  end

  // TXD monitor: finds a start bit, samples mid-bit, checks framing and byte.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en === 1'b1 && tx_mon === 1'b0) begin
        repeat (tx_per / 2) @(negedge clk);
        tx_start = tx_mon;
        for (int i = 0; i < 8; i++) begin
          repeat (tx_per) @(negedge clk);
          tx_got[i] = tx_mon;
        end
        repeat (tx_per) @(negedge clk);
        tx_stop = tx_mon;
        if (mon_en === 1'b1) begin
          check_output("tx start bit", tx_start, 1'b0);
          check_output("tx stop bit", tx_stop, 1'b1);
          if (tx_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL spurious tx byte: observed 0x%0h, none expected", tx_got);
          end else begin
            check_output("tx byte", tx_got, tx_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    code_tab = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                 5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                 5'b11010, 5'b11011, 5'b11100, 5'b11101};
    line_a = 1'b1; line_b = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
    mon_sel = 1'b0; mon_en = 1'b0; tx_per = BIT_OUT_A;
    repeat (3) @(negedge clk);

    check_output("reset TXD", txd_a, 1'b1);
    check_output("reset DATA", bus_a.DATA, 8'h00);
    check_output("reset LED", bus_a.LED, 8'h00);
    check_output("reset DATA_VALID", bus_a.DATA_VALID, 1'b0);
    check_output("reset ERR_FRAME", bus_a.ERR_FRAME, 1'b0);
    check_output("reset ERR_CODE", bus_a.ERR_CODE, 1'b0);
    check_output("reset ERR_OVERRUN", bus_a.ERR_OVERRUN, 1'b0);
    check_output("reset TXD b", txd_b, 1'b1);

    rst_a = 1'b0; rst_b = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;

    $display("[TB] single byte 0x41");
    fork
      send_byte(1'b0, 8'h41, 1'b1);
      begin : wait_dv
        int n;
        n = 0;
        while (bus_a.DATA_VALID !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        check_output("0x41 DATA_VALID seen", bus_a.DATA_VALID, 1'b1);
        check_output("TXD idle during DATA_VALID", txd_a, 1'b1);
        @(negedge clk);
        check_output("TXD start bit after DATA_VALID", txd_a, 1'b0);
        check_output("DATA_VALID one cycle", bus_a.DATA_VALID, 1'b0);
      end
    join
    drain("0x41 drained", 1000);
    check_output("DATA holds 0x41", bus_a.DATA, 8'h41);
    check_output("LED holds 0x41", bus_a.LED, 8'h41);

    $display("[TB] short low glitch");
    line_a = 1'b0;
    repeat (3) @(negedge clk);
    line_a = 1'b1;
    repeat (40) @(negedge clk);
    check_output("glitch ERR_FRAME", bus_a.ERR_FRAME, 1'b0);
    check_output("glitch ERR_CODE", bus_a.ERR_CODE, 1'b0);
    check_output("glitch DATA", bus_a.DATA, 8'h41);
    send_byte(1'b0, 8'h5A, 1'b1);
    drain("after glitch drained", 1000);
    check_output("after glitch DATA", bus_a.DATA, 8'h5A);

    $display("[TB] 256 bytes back-to-back");
    for (int i = 0; i < 256; i++) send_byte(1'b0, 8'(i), 1'b1);
    drain("stream drained", 2000);
    check_output("stream ERR_OVERRUN", bus_a.ERR_OVERRUN, 1'b0);
    check_output("stream ERR_CODE", bus_a.ERR_CODE, 1'b0);
    check_output("stream ERR_FRAME", bus_a.ERR_FRAME, 1'b0);

    $display("[TB] invalid symbol in s1");
    send_symbols(1'b0, code_tab[3], 5'b00000, 1'b1);
    count_tx_low(200, lows);
    check_output("code error TXD low cycles", lows, 0);
    check_output("code error ERR_CODE", bus_a.ERR_CODE, 1'b1);
    check_output("code error DATA unchanged", bus_a.DATA, 8'hFF);
    check_output("code error ERR_FRAME", bus_a.ERR_FRAME, 1'b0);

    $display("[TB] stop bit low");
    send_symbols(1'b0, code_tab[4], code_tab[2], 1'b0);
    line_a = 1'b1;
    repeat (30) @(negedge clk);
    check_output("frame error ERR_FRAME", bus_a.ERR_FRAME, 1'b1);
    check_output("frame error DATA unchanged", bus_a.DATA, 8'hFF);
    send_byte(1'b0, 8'h5A, 1'b1);
    drain("after frame error drained", 1000);
    check_output("after frame error DATA", bus_a.DATA, 8'h5A);

    $display("[TB] overrun with slow transmitter");
    mon_sel = 1'b1;
    tx_per = BIT_OUT_B;
    send_byte(1'b1, 8'h11, 1'b1);
    send_byte(1'b1, 8'h22, 1'b1);
    send_byte(1'b1, 8'h33, 1'b0);
    check_output("overrun ERR_OVERRUN", bus_b.ERR_OVERRUN, 1'b1);
    check_output("overrun DATA still updates", bus_b.DATA, 8'h33);
    drain("overrun drained", 1500);
    count_tx_low(300, lows);
    check_output("dropped byte not sent", lows, 0);

    $display("[TB] reset during transmit");
    send_byte(1'b1, 8'h44, 1'b0);
    repeat (3 * BIT_OUT_B) @(negedge clk);
    mon_en = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);
    check_output("mid-tx reset TXD", txd_b, 1'b1);
    check_output("mid-tx reset ERR_OVERRUN", bus_b.ERR_OVERRUN, 1'b0);
    check_output("mid-tx reset ERR_FRAME", bus_b.ERR_FRAME, 1'b0);
    check_output("mid-tx reset ERR_CODE", bus_b.ERR_CODE, 1'b0);
    check_output("mid-tx reset DATA", bus_b.DATA, 8'h00);
    check_output("mid-tx reset DATA_VALID", bus_b.DATA_VALID, 1'b0);
    rst_b = 1'b0;
    count_tx_low(400, lows);
    check_output("no partial byte after reset", lows, 0);
    check_output("scoreboard empty at end", rx_q.size() + tx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
